// File: rtl/mode7_pkg.sv
// Mode7 scan controller shared types: register map, FSM states,
// parameter bank layout and reset values.
package mode7_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;

  localparam logic [3:0] REG_ORIGINX  = 4'd0;
  localparam logic [3:0] REG_ORIGINY  = 4'd1;
  localparam logic [3:0] REG_OFFSETX  = 4'd2;
  localparam logic [3:0] REG_OFFSETY  = 4'd3;
  localparam logic [3:0] REG_TEXW     = 4'd4;
  localparam logic [3:0] REG_TEXH     = 4'd5;
  localparam logic [3:0] REG_SCALEXLO = 4'd6;
  localparam logic [3:0] REG_SCALEXHI = 4'd7;
  localparam logic [3:0] REG_SCALEYLO = 4'd8;
  localparam logic [3:0] REG_SCALEYHI = 4'd9;
  localparam logic [3:0] REG_ANGLE    = 4'd10;
  localparam logic [3:0] REG_CTRL     = 4'd11;

  localparam logic [15:0] ANGLE_LIMIT = 16'd360;
  localparam logic [23:0] SCALE_RST   = 24'h000100;

  typedef enum logic [1:0] {
    IDLE,
    COMMIT,
    RUN,
    DRAIN
  } state_e;

  typedef struct packed {
    logic [15:0] originx;
    logic [15:0] originy;
    logic [15:0] offsetx;
    logic [15:0] offsety;
    logic [15:0] texturew;
    logic [15:0] textureh;
    logic [15:0] angle;
    logic [23:0] scalex;
    logic [23:0] scaley;
  } bank_t;

  localparam bank_t BANK_RST = '{
    16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0,
    SCALE_RST, SCALE_RST
  };

  function automatic logic cfg_reject(
    input logic [3:0]  addr,
    input logic [15:0] wdata
  );
    return (addr > REG_CTRL) ||
           ((addr == REG_ANGLE) && (wdata >= ANGLE_LIMIT));
  endfunction

endpackage

// File: rtl/mode7_px_fifo.sv
// Synchronous pixel FIFO ({sol, sof, data}) with occupancy count.
// Storage resets to zero so the head reads 0 while empty after reset.
module mode7_px_fifo #(
  parameter int AW = 2,
  parameter int W  = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] rdata_o,
  output logic [AW:0]  count_o,
  output logic         empty_o
);

  localparam int D = 1 << AW;

  logic [W-1:0]  mem_q [D];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [AW:0]   cnt_q;
  logic          wr;
  logic          rd;

  assign wr = push_i && (cnt_q != (AW+1)'(D));
  assign rd = pop_i && (cnt_q != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < D; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (wr) begin
        mem_q[wr_q] <= wdata_i;
        wr_q        <= wr_q + 1'b1;
      end
      if (rd) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + (AW+1)'(wr) - (AW+1)'(rd);
    end
  end

  assign rdata_o = mem_q[rd_q];
  assign count_o = cnt_q;
  assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/mode7_scan_ctrl.sv
// Mode7 frame sequencer: raster walk, frame-stable parameter bank, pixel FIFO.
// Define MODE7_STALL_CNT_EN to build the credit-stall counter on stall_cnt.
module mode7_scan_ctrl
  import mode7_pkg::*;
#(
  parameter int H_ACTIVE  = H_ACTIVE_DEF,
  parameter int V_ACTIVE  = V_ACTIVE_DEF,
  parameter int XFORM_LAT = 0,
  parameter int FIFO_AW   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_we,
  input  logic [3:0]  cfg_addr,
  input  logic [15:0] cfg_wdata,
  output logic        cfg_err,
  input  logic        start,
  output logic        busy,
  output logic        frame_done,
  output logic        overrun,
  output logic [15:0] xf_x,
  output logic [15:0] xf_y,
  output logic [15:0] xf_originx,
  output logic [15:0] xf_originy,
  output logic [15:0] xf_offsetx,
  output logic [15:0] xf_offsety,
  output logic [15:0] xf_texturew,
  output logic [15:0] xf_textureh,
  output logic [15:0] xf_angle,
  output logic [23:0] xf_scalex,
  output logic [23:0] xf_scaley,
  input  logic [7:0]  xf_color,
  output logic        px_valid,
  input  logic        px_ready,
  output logic [7:0]  px_data,
  output logic        px_sol,
  output logic        px_sof,
  output logic [31:0] stall_cnt
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CW    = FIFO_AW + 1;
  localparam int OW    = FIFO_AW + 2;

  state_e      state_q;
  bank_t       shadow_q;
  bank_t       active_q;
  logic        en_q;
  logic        pend_q;
  logic [15:0] x_q;
  logic [15:0] y_q;
  logic        busy_q;
  logic        done_q;
  logic        ovr_q;
  logic        err_q;
  logic [CW-1:0] inflight_q;

  logic [CW-1:0] fifo_cnt;
  logic [OW-1:0] occ;
  logic        fifo_empty;
  logic        pop;
  logic        credit;
  logic        issue;
  logic        drain_done;
  logic        cfg_ok;
  logic        commit_wr;
  logic [2:0]  iss_tag;
  logic [2:0]  exit_tag;
  logic [9:0]  head;

  assign cfg_ok    = cfg_we && !cfg_reject(cfg_addr, cfg_wdata);
  assign commit_wr = cfg_ok && (cfg_addr == REG_CTRL) && cfg_wdata[1];

  assign pop    = px_valid && px_ready;
  // A pop this cycle frees a slot, keeping full rate at 2^AW == LAT+1.
  assign occ    = OW'(inflight_q) + OW'(fifo_cnt) - OW'(pop);
  assign credit = occ < OW'(DEPTH);
  assign issue  = (state_q == RUN) && credit;

  assign iss_tag = {issue, x_q == '0, (x_q == '0) && (y_q == '0)};

  assign drain_done = (state_q == DRAIN) && (inflight_q == '0) &&
                      (fifo_cnt == CW'(pop));

  generate
    if (XFORM_LAT == 0) begin : g_comb
      assign exit_tag = iss_tag;
    end else begin : g_pipe
      logic [2:0] tag_q [XFORM_LAT];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < XFORM_LAT; i++) tag_q[i] <= '0;
        end else begin
          tag_q[0] <= iss_tag;
          for (int i = 1; i < XFORM_LAT; i++) tag_q[i] <= tag_q[i-1];
        end
      end
      assign exit_tag = tag_q[XFORM_LAT-1];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= BANK_RST;
      en_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      err_q <= cfg_we && cfg_reject(cfg_addr, cfg_wdata);
      if (cfg_ok) begin
        unique case (1'b1)
          cfg_addr == REG_ORIGINX:  shadow_q.originx  <= cfg_wdata;
          cfg_addr == REG_ORIGINY:  shadow_q.originy  <= cfg_wdata;
          cfg_addr == REG_OFFSETX:  shadow_q.offsetx  <= cfg_wdata;
          cfg_addr == REG_OFFSETY:  shadow_q.offsety  <= cfg_wdata;
          cfg_addr == REG_TEXW:     shadow_q.texturew <= cfg_wdata;
          cfg_addr == REG_TEXH:     shadow_q.textureh <= cfg_wdata;
          cfg_addr == REG_SCALEXLO: shadow_q.scalex[15:0]  <= cfg_wdata;
          cfg_addr == REG_SCALEXHI: shadow_q.scalex[23:16] <= cfg_wdata[7:0];
          cfg_addr == REG_SCALEYLO: shadow_q.scaley[15:0]  <= cfg_wdata;
          cfg_addr == REG_SCALEYHI: shadow_q.scaley[23:16] <= cfg_wdata[7:0];
          cfg_addr == REG_ANGLE:    shadow_q.angle    <= cfg_wdata;
          cfg_addr == REG_CTRL:     en_q             <= cfg_wdata[0];
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      active_q   <= BANK_RST;
      pend_q     <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovr_q      <= 1'b0;
      inflight_q <= '0;
    end else begin
      done_q     <= 1'b0;
      ovr_q      <= start && (state_q != IDLE);
      inflight_q <= inflight_q + CW'(issue) - CW'(exit_tag[2]);
      unique case (state_q)
        IDLE: begin
          if (start && en_q) begin
            state_q <= COMMIT;
            busy_q  <= 1'b1;
          end
        end
        COMMIT: begin
          if (pend_q) begin
            active_q <= shadow_q;
            pend_q   <= 1'b0;
          end
          x_q     <= '0;
          y_q     <= '0;
          state_q <= RUN;
        end
        RUN: begin
          if (issue) begin
            if (x_q == 16'(H_ACTIVE - 1)) begin
              x_q <= '0;
              if (y_q == 16'(V_ACTIVE - 1)) state_q <= DRAIN;
              else y_q <= y_q + 16'd1;
            end else begin
              x_q <= x_q + 16'd1;
            end
          end
        end
        DRAIN: begin
          if (drain_done) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
      endcase
      // A request landing in the COMMIT cycle survives for the next frame.
      if (commit_wr) pend_q <= 1'b1;
    end
  end

  mode7_px_fifo #(
    .AW (FIFO_AW),
    .W  (10)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (exit_tag[2]),
    .pop_i   (pop),
    .wdata_i ({exit_tag[1], exit_tag[0], xf_color}),
    .rdata_o (head),
    .count_o (fifo_cnt),
    .empty_o (fifo_empty)
  );

`ifdef MODE7_STALL_CNT_EN
  logic [31:0] stall_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (state_q == COMMIT) begin
      stall_q <= '0;
    end else if ((state_q == RUN) && !credit && (stall_q != '1)) begin
      stall_q <= stall_q + 32'd1;
    end
  end
  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

  assign cfg_err     = err_q;
  assign busy        = busy_q;
  assign frame_done  = done_q;
  assign overrun     = ovr_q;
  assign xf_x        = x_q;
  assign xf_y        = y_q;
  assign xf_originx  = active_q.originx;
  assign xf_originy  = active_q.originy;
  assign xf_offsetx  = active_q.offsetx;
  assign xf_offsety  = active_q.offsety;
  assign xf_texturew = active_q.texturew;
  assign xf_textureh = active_q.textureh;
  assign xf_angle    = active_q.angle;
  assign xf_scalex   = active_q.scalex;
  assign xf_scaley   = active_q.scaley;
  assign px_valid    = !fifo_empty;
  assign px_sol      = head[9];
  assign px_sof      = head[8];
  assign px_data     = head[7:0];

endmodule
